regfile_dump: RTL and testbench
===============================

// Module: regfile_dump
// PURPOSE
//  Read-side master for the 32x64 LEGv8 regfile: on a start pulse it walks X0..X31 through one read port.
//  Each value is streamed out on a valid/ready beat interface (debug/trace dump of architectural state).
//  Sits beside the one-cycle core, shares regfile read address ra1 via a debug mux; the core is halted during a dump.
// PARAMETERS
//  N_REGS  32  registers walked, indices 0..N_REGS-1 (31 = XZR, must read 0)
//  DW      64  data width
//  AW      5   register address width, $clog2(N_REGS)
// PORTS
//  clk            in   1   clock, all state on posedge
//  reset          in   1   asynchronous, active-low reset
//  start          in   1   begin dump; sampled only in IDLE
//  busy           out  1   high in any state other than IDLE
//  done           out  1   one-cycle pulse after the final beat is accepted
//  ra             out  AW  regfile read address (combinational read assumed)
//  rd             in   DW  regfile read data for ra, same cycle
//  dump_valid     out  1   beat present
//  dump_ready     in   1   sink accepts beat; fire = dump_valid & dump_ready
//  dump_idx       out  AW  register index of current beat
//  dump_data      out  DW  register value of current beat
//  dump_is_csum   out  1   current beat is checksum beat (0 without macro)
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE, ptr=0, ra=0, busy=0, done=0, dump_valid=0, dump_idx=0, dump_data=0, dump_is_csum=0, csum=0.
//  ra = ptr (registered pointer), never X/Z.
//  FSM IDLE -> READ -> HOLD -> [CSUM] -> DONE -> IDLE.
//  IDLE: start=1 -> READ, ptr=0, csum=0. start in any other state is ignored.
//  READ: capture dump_data<=rd, dump_idx<=ptr, ptr<=ptr+1, dump_valid<=1 -> HOLD.
//   First beat valid 2 cycles after start sampled.
//  HOLD: dump_valid=1; dump_data/dump_idx held stable while !dump_ready.
//   fire & dump_idx!=N_REGS-1: capture next (rd at ra=ptr), ptr++, stay HOLD -> 1 beat/cycle with ready held high.
//   fire & dump_idx==N_REGS-1: dump_valid<=0 -> DONE (or CSUM when enabled).
//  DONE: done=1 for exactly one cycle, busy=1 -> IDLE.
//  ptr never wraps: it stops at N_REGS, ra held at N_REGS-1 when ptr==N_REGS (no out-of-range read).
//  Value of Xn is sampled the cycle its beat is captured; regfile writes before that are visible (no snapshot).
//  Reset mid-dump: immediate abort to IDLE, dump_valid drops asynchronously, no done pulse; next start restarts at X0.
//  dump_ready ignored while dump_valid=0.
// CONFIGURATION
//  DUMP_CHECKSUM_EN defined: csum ^= dump_data on every register fire.
//   After the last register fire -> CSUM: one extra beat, dump_valid=1, dump_is_csum=1, dump_idx=N_REGS-1, dump_data=csum.
//   Beat held until fire, then -> DONE.
//  DUMP_CHECKSUM_EN undefined: no CSUM state, no csum register, dump_is_csum tied 0.
// STRUCTURE
//  Shared package regdump_pkg: state enum (IDLE, READ, HOLD, CSUM, DONE), XZR_IDX=5'd31, default widths.
//  No sub-module: pointer, FSM and XOR accumulator are flat in regfile_dump.
//  Bench pairs it with the existing regfile (X0..X30 preloaded with value i).
// TESTING
//  1 start, dump_ready=1 -> 32 back-to-back beats idx 0..31, data=idx for 0..30, idx31 data=0; done 1 cycle after last fire; busy low after.
//  2 dump_ready toggling 1,0,0,1 per cycle -> no beat lost or duplicated; data/idx stable across stalls; still 32 beats in order.
//  3 start pulsed again at beat 7 -> ignored, sequence unchanged, exactly one done.
//  4 reset=0 during beat 10 -> dump_valid=0 and busy=0 without waiting for clk; next start yields idx 0 first.
//  5 regfile write X5<=64'hDEAD_BEEF at beat 2 -> beat 5 carries 64'hDEAD_BEEF; rewrite X1 at beat 3 -> not reflected.
//  6 DUMP_CHECKSUM_EN defined -> 33rd beat dump_is_csum=1, dump_idx=31, dump_data=64'h1F; without macro dump_is_csum never 1.

Source files
------------

// File: rtl/regdump_pkg.sv
// Shared definitions for the regfile dump master: FSM state encoding,
// the XZR index and default widths for the 32x64 LEGv8 register file.
package regdump_pkg;

    localparam int N_REGS_DEF = 32;
    localparam int DW_DEF     = 64;
    localparam int AW_DEF     = 5;

    // X31 is the zero register; its beat always carries 0.
    localparam logic [4:0] XZR_IDX = 5'd31;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        HOLD = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/regfile_dump.sv
// regfile_dump: walks X0..X(N_REGS-1) through one regfile read port and
// streams each value out on a valid/ready beat interface.
// Optional feature macro: DUMP_CHECKSUM_EN appends one XOR-checksum beat
// after the last register beat.
module regfile_dump
    import regdump_pkg::*;
#(
    parameter int N_REGS = N_REGS_DEF,
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ra,
    input  logic [DW-1:0] rd,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [AW-1:0] dump_idx,
    output logic [DW-1:0] dump_data,
    output logic          dump_is_csum
);

    localparam logic [AW:0]   PTR_END  = (AW+1)'(N_REGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(N_REGS - 1);
    localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

    state_t      state;
    logic [AW:0] ptr;      // one bit wider so it can rest at N_REGS
    logic        fire;
    logic        last_beat;

`ifdef DUMP_CHECKSUM_EN
    logic [DW-1:0] csum;
`else
    assign dump_is_csum = 1'b0;
`endif

    assign fire      = dump_valid & dump_ready;
    assign last_beat = (dump_idx == LAST_IDX);

    // Pointer parks at N_REGS after the last capture; clamp so the read stays in range.
    assign ra = (ptr == PTR_END) ? LAST_IDX : ptr[AW-1:0];

    // Dump FSM with registered beat, busy and done outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dump_valid <= 1'b0;
            dump_idx   <= '0;
            dump_data  <= '0;
`ifdef DUMP_CHECKSUM_EN
            dump_is_csum <= 1'b0;
            csum         <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= READ;
                        ptr   <= '0;
                        busy  <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                        csum  <= '0;
`endif
                    end
                end
                READ: begin
                    dump_data  <= rd;
                    dump_idx   <= ptr[AW-1:0];
                    ptr        <= ptr + PTR_ONE;
                    dump_valid <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (fire) begin
`ifdef DUMP_CHECKSUM_EN
                        csum <= csum ^ dump_data;
`endif
                        if (!last_beat) begin
                            // Back-to-back: the next register is read the same cycle the current beat leaves.
                            dump_data <= rd;
                            dump_idx  <= ptr[AW-1:0];
                            ptr       <= ptr + PTR_ONE;
                        end else begin
`ifdef DUMP_CHECKSUM_EN
                            // Index stays at the last register; data is the running XOR including this beat.
                            dump_data    <= csum ^ dump_data;
                            dump_is_csum <= 1'b1;
                            state        <= CSUM;
`else
                            dump_valid <= 1'b0;
                            done       <= 1'b1;
                            state      <= DONE;
`endif
                        end
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                CSUM: begin
                    if (fire) begin
                        dump_valid   <= 1'b0;
                        dump_is_csum <= 1'b0;
                        done         <= 1'b1;
                        state        <= DONE;
                    end
                end
`endif
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a regfile array with combinational read, a
// beat-level reference model checked every cycle, and literal pins per test.
// Honours DUMP_CHECKSUM_EN for the extra checksum beat.
module tb_regfile_dump;

`ifdef DUMP_CHECKSUM_EN
    localparam int CSUM_BEATS = 1;
`else
    localparam int CSUM_BEATS = 0;
`endif
    localparam int NBEATS = 32 + CSUM_BEATS;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  ra;
    logic [63:0] rd;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_idx;
    logic [63:0] dump_data;
    logic        dump_is_csum;

    logic [63:0] rf [0:31];
    assign rd = rf[ra];

    always #5 clk = ~clk;

    regfile_dump dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .ra           (ra),
        .rd           (rd),
        .dump_valid   (dump_valid),
        .dump_ready   (dump_ready),
        .dump_idx     (dump_idx),
        .dump_data    (dump_data),
        .dump_is_csum (dump_is_csum)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: the beat the sink should currently see.
    bit          m_active, m_first, m_valid, m_done, m_csumb;
    int          m_idx;
    logic [63:0] m_data, m_acc;

    // Last sampled DUT beat, plus a log of accepted beats for literal pins.
    logic [4:0]  p_idx;
    logic [63:0] p_data;
    logic        p_csum;
    int          got_cnt = 0;
    int          done_cnt = 0;
    int          csum_seen = 0;
    logic [4:0]  got_idx  [0:63];
    logic [63:0] got_data [0:63];
    logic        got_csum [0:63];

    task automatic load_beat(input int i);
        m_valid = 1'b1;
        m_idx   = i;
        m_data  = (i == 31) ? 64'd0 : rf[i];
        m_csumb = 1'b0;
    endtask

    // Compare process: inputs change at negedge+1, so at the negedge the
    // values present are exactly those the DUT saw at the preceding posedge.
    always @(negedge clk) begin
        bit fire;
        if (!reset) begin
            m_active = 0; m_first = 0; m_valid = 0; m_done = 0; m_csumb = 0;
            m_idx = 0; m_data = '0; m_acc = '0;
            chk("rst_valid", dump_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_ra", ra, 0);
            chk("rst_idx", dump_idx, 0);
            chk("rst_data", dump_data, 0);
            chk("rst_csum", dump_is_csum, 0);
        end else begin
            fire = m_valid && (dump_ready === 1'b1);
            if (fire) begin
                if (got_cnt < 64) begin
                    got_idx[got_cnt]  = p_idx;
                    got_data[got_cnt] = p_data;
                    got_csum[got_cnt] = p_csum;
                end
                $display("beat %0d accepted: idx=%0d data=%h csum=%0b", got_cnt, p_idx, p_data, p_csum);
                got_cnt++;
            end
            if (m_done) begin
                m_done   = 0;
                m_active = 0;
            end else if (!m_active) begin
                if (start) begin
                    m_active = 1;
                    m_first  = 1;
                    m_acc    = '0;
                end
            end else if (m_first) begin
                m_first = 0;
                load_beat(0);
            end else if (fire) begin
                if (!m_csumb) m_acc = m_acc ^ m_data;
                if (m_csumb || (m_idx == 31 && CSUM_BEATS == 0)) begin
                    m_valid = 0;
                    m_csumb = 0;
                    m_done  = 1;
                end else if (m_idx == 31) begin
                    m_csumb = 1;
                    m_data  = m_acc;
                end else begin
                    load_beat(m_idx + 1);
                end
            end
            chk("busy", busy, m_active);
            chk("done", done, m_done);
            chk("valid", dump_valid, m_valid);
            chk("is_csum", dump_is_csum, m_valid & m_csumb);
            chk("ra_known", $isunknown(ra), 0);
            if (m_valid) begin
                chk("idx", dump_idx, m_idx);
                chk("data", dump_data, m_data);
            end
            if (done) done_cnt++;
            if (dump_is_csum) csum_seen++;
        end
        p_idx  = dump_idx;
        p_data = dump_data;
        p_csum = dump_is_csum;
    end

    // One dump from start to done. mode 0: ready high, 1: ready 1,0,0,1,
    // 2: random ready with random regfile writes, 3: stray start at beat 7,
    // 5: X5/X1 rewrites mid-dump.
    task automatic run(input int mode, input string tag);
        int         d0;
        bit         seen, s7, w5, w1;
        logic [3:0] pat;
        pat  = 4'b1001;
        d0   = done_cnt;
        seen = 0; s7 = 0; w5 = 0; w1 = 0;
        @(negedge clk); #1;
        got_cnt    = 0;
        start      = 1'b1;
        dump_ready = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (mode == 3 && got_cnt == 7 && !s7) begin
                start = 1'b1;
                s7    = 1;
            end
            case (mode)
                1:       dump_ready = pat[c % 4];
                2:       dump_ready = 1'($urandom_range(0, 1));
                default: dump_ready = 1'b1;
            endcase
            if (mode == 5 && got_cnt == 2 && !w5) begin
                rf[5] = 64'hDEAD_BEEF;
                w5    = 1;
            end
            if (mode == 5 && got_cnt == 3 && !w1) begin
                rf[1] = 64'h1111_2222_3333_4444;
                w1    = 1;
            end
            if (mode == 2 && $urandom_range(0, 3) == 0)
                rf[$urandom_range(1, 30)] = {$urandom, $urandom};
            if (done_cnt != d0) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            bad++;
            total++;
            $display("FAIL %s_timeout: got no done want done within 600 cycles", tag);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk({tag, "_done_once"}, done_cnt - d0, 1);
        chk({tag, "_beats"}, got_cnt, NBEATS);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int errs;
        int d0;
        bit hit;
        for (int i = 0; i < 32; i++) rf[i] = (i == 31) ? 64'd0 : 64'(i);
        reset      = 1'b0;
        start      = 1'b0;
        dump_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);

        // 1: straight dump, ready held high
        run(0, "t1");
        chk("t1_first_idx", got_idx[0], 0);
        chk("t1_x0", got_data[0], 0);
        chk("t1_x30", got_data[30], 64'd30);
        chk("t1_x31_idx", got_idx[31], 31);
        chk("t1_x31_zero", got_data[31], 0);
`ifdef DUMP_CHECKSUM_EN
        chk("t6_csum_flag", got_csum[32], 1);
        chk("t6_csum_idx", got_idx[32], 31);
        chk("t6_csum_data", got_data[32], 64'h1F);
`endif

        // 2: stalls 1,0,0,1
        run(1, "t2");
        errs = 0;
        for (int k = 0; k < 32; k++)
            if (got_idx[k] !== 5'(k) || got_data[k] !== ((k == 31) ? 64'd0 : 64'(k))) errs++;
        chk("t2_order", errs, 0);

        // 3: stray start mid-dump
        run(3, "t3");
        chk("t3_x7", got_data[7], 64'd7);

        // 4: asynchronous abort during beat 10
        d0  = done_cnt;
        hit = 0;
        @(negedge clk); #1;
        got_cnt    = 0;
        start      = 1'b1;
        dump_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (got_cnt == 10) begin
                hit = 1;
                break;
            end
        end
        chk("t4_reached_beat10", hit, 1);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("t4_async_valid", dump_valid, 0);
        chk("t4_async_busy", busy, 0);
        @(negedge clk); #1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("t4_no_done", done_cnt - d0, 0);
        run(0, "t4r");
        chk("t4_restart_idx", got_idx[0], 0);
        chk("t4_restart_data", got_data[0], 0);

        // 5: writes visible only to registers not yet captured
        run(5, "t5");
        chk("t5_x5_new", got_data[5], 64'hDEAD_BEEF);
        chk("t5_x1_old", got_data[1], 64'd1);
        rf[1] = 64'd1;
        rf[5] = 64'd5;

        // Randomised ready and regfile traffic
        for (int r = 0; r < 3; r++) run(2, "rnd");

`ifndef DUMP_CHECKSUM_EN
        chk("t6_never_csum", csum_seen, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
